// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code pulse counter family: code conversion,
// width calculation and direction constants.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_w_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Callers zero-extend narrower counts; the upper zeros leave the low bits exact.
    function automatic gray_w_t bin2gray(input gray_w_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_w_t gray2bin(input gray_w_t g);
        gray_w_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pulse_prescaler.sv
// Divides enabled clock cycles by DIV and flags the cycle that completes a period.
// clr restarts the period; the phase freezes while clk_en is low.
module pulse_prescaler
    import gray_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic clr,
    output logic tick_o
);

    localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        tick_o = clk_en & (pre_q == LAST);
        pre_d  = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (clk_en) begin
            pre_d = tick_o ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/gray_pulse_counter.sv
// N-bit up/down Gray counter stepped by a prescaler, with binary load and
// wrap or saturate behaviour at the limits. All outputs are registered.
module gray_pulse_counter
    import gray_pkg::*;
#(
    parameter int N    = 4,
    parameter int DIV  = 1000,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         tick,
    output logic         wrap_pulse
);

    localparam logic [N-1:0] MAX_VAL = '1;

    logic         step;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         tick_q, tick_d;
    logic         wrap_q, wrap_d;

    pulse_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clk_en(clk_en),
        .clr   (load),
        .tick_o(step)
    );

    // A load overrides a coincident step; saturate mode still ticks and flags the blocked step.
    always_comb begin
        bin_d  = bin_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (step) begin
            tick_d = 1'b1;
            if (dir == DIR_UP) begin
                if (bin_q == MAX_VAL) begin
                    wrap_d = 1'b1;
                    if (WRAP) begin
                        bin_d = '0;
                    end
                end else begin
                    bin_d = bin_q + N'(1);
                end
            end else begin
                if (bin_q == '0) begin
                    wrap_d = 1'b1;
                    if (WRAP) begin
                        bin_d = MAX_VAL;
                    end
                end else begin
                    bin_d = bin_q - N'(1);
                end
            end
        end
        gray_d = N'(bin2gray(gray_w_t'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out    = bin_q;
    assign gray_out   = gray_q;
    assign tick       = tick_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_gray_pulse_counter.sv
// Bench for gray_pulse_counter: four configurations share one stimulus stream,
// a reference model feeds a scoreboard, and table/hand sequences check fixed values.
module tb_gray_pulse_counter;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       t_rst = 1'b1;
    logic       t_en = 1'b0;
    logic       t_dir = 1'b1;
    logic       t_load = 1'b0;
    logic [3:0] t_lval = 4'd0;

    logic [3:0] bin_o [NI];
    logic [3:0] gray_o[NI];
    logic       tick_o[NI];
    logic       wrap_o[NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instances: 0 = DIV1 wrap, 1 = DIV3 wrap, 2 = DIV1 saturate, 3 = DIV4 wrap
    gray_pulse_counter #(.N(4), .DIV(1), .WRAP(1'b1)) u_w1 (
        .clk(clk), .rst(t_rst), .clk_en(t_en), .dir(t_dir), .load(t_load), .load_val(t_lval),
        .gray_out(gray_o[0]), .bin_out(bin_o[0]), .tick(tick_o[0]), .wrap_pulse(wrap_o[0]));
    gray_pulse_counter #(.N(4), .DIV(3), .WRAP(1'b1)) u_d3 (
        .clk(clk), .rst(t_rst), .clk_en(t_en), .dir(t_dir), .load(t_load), .load_val(t_lval),
        .gray_out(gray_o[1]), .bin_out(bin_o[1]), .tick(tick_o[1]), .wrap_pulse(wrap_o[1]));
    gray_pulse_counter #(.N(4), .DIV(1), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(t_rst), .clk_en(t_en), .dir(t_dir), .load(t_load), .load_val(t_lval),
        .gray_out(gray_o[2]), .bin_out(bin_o[2]), .tick(tick_o[2]), .wrap_pulse(wrap_o[2]));
    gray_pulse_counter #(.N(4), .DIV(4), .WRAP(1'b1)) u_d4 (
        .clk(clk), .rst(t_rst), .clk_en(t_en), .dir(t_dir), .load(t_load), .load_val(t_lval),
        .gray_out(gray_o[3]), .bin_out(bin_o[3]), .tick(tick_o[3]), .wrap_pulse(wrap_o[3]));

    typedef struct {
        int         inst;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       tick;
        logic       wrap;
    } sb_t;

    typedef struct {
        logic       rst, en, dir, load;
        logic [3:0] lval;
        int         sel;
        logic [3:0] eb, eg;
        logic       et, ew;
        string      name;
    } vec_t;

    sb_t        sb_q[$];
    vec_t       vecs[$];
    int         m_div [NI] = '{1, 3, 1, 4};
    bit         m_wrap[NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int         m_pre [NI];
    logic [3:0] m_b   [NI];
    logic [3:0] prev_gray[NI];
    logic [3:0] prev_bin [NI];
    logic [3:0] gray_seq[17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of one clock edge for every configuration.
    task automatic modelEdge();
        for (int i = 0; i < NI; i++) begin
            sb_t e;
            e.inst = i;
            e.tick = 1'b0;
            e.wrap = 1'b0;
            if (t_rst) begin
                m_pre[i] = 0;
                m_b[i]   = 4'd0;
            end else if (t_load) begin
                m_pre[i] = 0;
                m_b[i]   = t_lval;
            end else if (t_en) begin
                if (m_pre[i] == m_div[i] - 1) begin
                    m_pre[i] = 0;
                    e.tick   = 1'b1;
                    if (t_dir) begin
                        if (m_b[i] == 4'd15) begin
                            e.wrap = 1'b1;
                            if (m_wrap[i]) m_b[i] = 4'd0;
                        end else m_b[i] = m_b[i] + 4'd1;
                    end else begin
                        if (m_b[i] == 4'd0) begin
                            e.wrap = 1'b1;
                            if (m_wrap[i]) m_b[i] = 4'd15;
                        end else m_b[i] = m_b[i] - 4'd1;
                    end
                end else begin
                    m_pre[i] = m_pre[i] + 1;
                end
            end
            e.bin  = m_b[i];
            e.gray = m_b[i] ^ (m_b[i] >> 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic checkOutput();
        while (sb_q.size() > 0) begin
            sb_t e;
            int  i;
            e = sb_q.pop_front();
            i = e.inst;
            checkVal($sformatf("sb%0d.bin", i),  32'(bin_o[i]),  32'(e.bin));
            checkVal($sformatf("sb%0d.gray", i), 32'(gray_o[i]), 32'(e.gray));
            checkVal($sformatf("sb%0d.tick", i), 32'(tick_o[i]), 32'(e.tick));
            checkVal($sformatf("sb%0d.wrap", i), 32'(wrap_o[i]), 32'(e.wrap));
            if (tick_o[i] === 1'b1 && bin_o[i] !== prev_bin[i]) begin
                checkVal($sformatf("gray1bit%0d", i), 32'($countones(gray_o[i] ^ prev_gray[i])), 32'd1);
            end
            prev_gray[i] = gray_o[i];
            prev_bin[i]  = bin_o[i];
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic d,
                                 input logic ld, input logic [3:0] lv);
        t_rst  = r;
        t_en   = en;
        t_dir  = d;
        t_load = ld;
        t_lval = lv;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic vec_t mkv(input logic r, en, d, ld, input logic [3:0] lv, input int sel,
                                 input logic [3:0] eb, eg, input logic et, ew, input string name);
        vec_t v;
        v.rst = r; v.en = en; v.dir = d; v.load = ld; v.lval = lv; v.sel = sel;
        v.eb = eb; v.eg = eg; v.et = et; v.ew = ew; v.name = name;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_pre[i] = 0; m_b[i] = 4'd0; prev_gray[i] = 4'd0; prev_bin[i] = 4'd0;
        end

        vecs.push_back(mkv(1, 0, 1, 0, 0, 0, 4'd0, gray_seq[0], 0, 0, "reset"));
        for (int k = 1; k <= 16; k++) begin
            vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 4'(k), gray_seq[k], 1, (k == 16), "up_wrap"));
        end
        vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 4'd0,  4'b0000, 0, 0, "reset2"));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 4'd15, 4'b1000, 1, 1, "down_wrap"));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 4'd14, 4'b1001, 1, 0, "down_14"));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 4'd15, 4'b1000, 1, 0, "dir_change"));
        vecs.push_back(mkv(0, 1, 1, 1, 9, 0, 4'd9,  4'b1101, 0, 0, "load_prio"));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 4'd10, 4'b1111, 1, 0, "after_load"));
        vecs.push_back(mkv(0, 0, 1, 1, 5, 0, 4'd5,  4'b0111, 0, 0, "load_noen"));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 4'd5,  4'b0111, 0, 0, "hold_noen"));
        vecs.push_back(mkv(0, 1, 1, 1, 14, 2, 4'd14, 4'b1001, 0, 0, "sat_load"));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 2, 4'd15, 4'b1000, 1, 0, "sat_to15"));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 2, 4'd15, 4'b1000, 1, 1, "sat_hold15"));
        vecs.push_back(mkv(0, 1, 0, 1, 0, 2, 4'd0,  4'b0000, 0, 0, "sat_load0"));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 2, 4'd0,  4'b0000, 1, 1, "sat_hold0"));

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].rst, vecs[n].en, vecs[n].dir, vecs[n].load, vecs[n].lval);
            checkVal({vecs[n].name, ".bin"},  32'(bin_o[vecs[n].sel]),  32'(vecs[n].eb));
            checkVal({vecs[n].name, ".gray"}, 32'(gray_o[vecs[n].sel]), 32'(vecs[n].eg));
            checkVal({vecs[n].name, ".tick"}, 32'(tick_o[vecs[n].sel]), 32'(vecs[n].et));
            checkVal({vecs[n].name, ".wrap"}, 32'(wrap_o[vecs[n].sel]), 32'(vecs[n].ew));
        end

        // DIV=3 spacing, then a five-cycle enable gap one cycle into a period
        applyStimulus(1, 1, 1, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkVal("pre3.tick", 32'(tick_o[1]), 32'(k % 3 == 0));
            checkVal("pre3.bin", 32'(bin_o[1]), 32'(k / 3));
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkVal("gap.pre_tick", 32'(tick_o[1]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkVal("gap.tick", 32'(tick_o[1]), 32'd0);
            checkVal("gap.bin", 32'(bin_o[1]), 32'd3);
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkVal("gap.resume1", 32'(tick_o[1]), 32'd0);
        applyStimulus(0, 1, 1, 0, 0);
        checkVal("gap.resume2", 32'(tick_o[1]), 32'd1);
        checkVal("gap.bin4", 32'(bin_o[1]), 32'd4);

        // DIV=4 reset mid-prescale while the count reads 6
        applyStimulus(1, 1, 1, 0, 0);
        for (int k = 1; k <= 24; k++) applyStimulus(0, 1, 1, 0, 0);
        checkVal("rst4.bin6", 32'(bin_o[3]), 32'd6);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        checkVal("rst4.bin0", 32'(bin_o[3]), 32'd0);
        checkVal("rst4.gray0", 32'(gray_o[3]), 32'd0);
        checkVal("rst4.tick0", 32'(tick_o[3]), 32'd0);
        checkVal("rst4.wrap0", 32'(wrap_o[3]), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkVal("rst4.first_tick", 32'(tick_o[3]), 32'(k == 4));
            checkVal("rst4.first_bin", 32'(bin_o[3]), 32'(k == 4));
        end

        // Random stream checked only against the model
        for (int k = 0; k < 200; k++) begin
            applyStimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                          4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_pulse_counter.md
# gray_pulse_counter

Parametrised N-bit Gray-code counter with a built-in prescaler, up/down direction, synchronous binary load and a selectable wrap/saturate mode. It is the next-generation replacement for the fixed 4-bit Gray counter that drives the board LEDs in the pulse-generator lab. The prescaler turns the fast system clock into a visible step rate. Registered tick and wrap pulses are provided for downstream pulse logic.

## Interface
- N, 4: counter width in bits, ≥2
- DIV, 1000: prescaler period in enabled clk cycles, ≥1
- WRAP, 1: 1 = wrap around at the limits, 0 = saturate at the limits
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-high
- clk_en  in  1  global enable for prescaler and counting
- dir  in  1  count direction: 1 = up, 0 = down
- load  in  1  synchronous load strobe
- load_val  in  N  binary value to load
- gray_out  out  N  current count in Gray code, registered
- bin_out  out  N  current count in binary, registered
- tick  out  1  one-cycle pulse, high in the cycle the new count appears
- wrap_pulse  out  1  one-cycle pulse marking a wrap, or a blocked step in saturate mode

## Operation
- **State:** prescaler `pre` of width max(1, clog2(DIV)); binary count `b` of N bits.
- **Derived outputs:** `gray_out = b ^ (b >> 1)`; `bin_out = b`. Both are registered copies, so they are always mutually consistent.
- **Step condition:** `step = clk_en & (pre == DIV-1)`.
- **Prescaler:**
  - If clk_en is high, `pre` advances and wraps from DIV-1 to 0.
  - If clk_en is low, `pre` holds.
  - With DIV=1, `pre` is constantly 0 and every enabled cycle is a step.
- **Priority, per edge:** rst > load > step > hold.
- **rst:**
  - `pre`=0, `b`=0.
  - gray_out=0, bin_out=0, tick=0, wrap_pulse=0.
  - Applies mid-count and mid-prescale with no residue.
- **load:**
  - `b` ← load_val and `pre` ← 0, regardless of clk_en.
  - tick=0 and wrap_pulse=0 on that edge.
  - A coincident step is discarded.
- **step, up direction:**
  - If `b` = 2^N−1 and WRAP=1: `b` ← 0 and wrap_pulse=1.
  - If `b` = 2^N−1 and WRAP=0: `b` holds and wrap_pulse=1.
  - Otherwise `b` ← `b`+1.
- **step, down direction:**
  - If `b` = 0 and WRAP=1: `b` ← 2^N−1 and wrap_pulse=1.
  - If `b` = 0 and WRAP=0: `b` holds and wrap_pulse=1.
  - Otherwise `b` ← `b`−1.
- **tick** is 1 on every step edge, including a saturated hold.
- **dir** is sampled only on step edges. A change takes effect at the next step and does not disturb `pre`.
- **Gray property:** every change of gray_out caused by a step differs from the previous value in exactly 1 bit.
  - Wrap in either direction also obeys this (2^N−1 ↔ 0: Gray 10…0 ↔ 00…0).
  - Loads may change any number of bits.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- **Step latency:** count, tick and wrap_pulse all update at the edge where `step` is true. They are visible in the following cycle and last exactly one cycle.
- **Step spacing:** with clk_en held high, tick period is DIV cycles.
  - The first tick after rst or load follows DIV enabled cycles later.
- **Load latency:** load_val appears on bin_out and gray_out one cycle after the edge where load is sampled.
- **Reset latency:** outputs read 0 the cycle after the rst edge.
- **Enable gaps:** deasserting clk_en freezes the prescaler phase. Re-enabling resumes from the frozen `pre`, so enabled cycles accumulate across gaps.

## Structure
- **Package `gray_pkg`:**
  - `bin2gray` function (N-generic).
  - `gray2bin` function, for benches and future decoders.
  - `clog2` helper.
  - Constants `DIR_UP`=1 and `DIR_DOWN`=0.
- **Sub-module `pulse_prescaler`:**
  - Parameter DIV.
  - Ports clk, rst, clk_en, clr, tick_o.
  - `clr` is driven by load.
  - Reusable by the other pulse-generator blocks.
- **Top level:** holds the binary counter, the limit/wrap logic and the output registers.

## Test plan
- **Count up through wrap:** N=4, DIV=1, clk_en=1, dir=1 after rst.
  - Expect gray_out 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - Expect wrap_pulse=1 only with the final 0000.
  - Expect tick=1 every cycle.
- **Prescaler spacing:** N=4, DIV=3.
  - Expect tick exactly every 3rd cycle.
  - Lower clk_en for 5 cycles mid-period: counter and phase hold, and the next tick arrives after the remaining enabled cycles.
- **Down wrap and direction change:** N=4, DIV=1, from rst with dir=0.
  - Expect bin_out 15 (gray 1000) with wrap_pulse=1, then 14.
  - Set dir=1: next step gives bin_out 15 and wrap_pulse=0.
- **Load priority:** DIV=1, load=1 with load_val=9 on a step edge.
  - Expect bin_out=9, gray_out=1101, tick=0, wrap_pulse=0.
  - Expect the next step to give 10.
  - Load with clk_en=0 still gives load_val.
- **Saturate mode:** WRAP=0, DIV=1.
  - Up from 14: 15, then 15 held with tick=1 and wrap_pulse=1.
  - Down at 0 holds 0.
- **Reset mid-operation:** DIV=4, rst asserted between ticks while bin_out=6.
  - Expect all outputs 0 next cycle.
  - Expect the first tick exactly 4 cycles after rst deasserts.
  - A checker confirms a single-bit gray_out change on every step throughout.
